bst_engine: RTL

- Parametrised binary-search-tree key store. Successor to the board-level 4-bit/7-node tree demo.
- Supports configurable key width and node count.
- Commands (find/insert/clear/in-order traverse) arrive through a valid/ready handshake and are executed by a multi-cycle FSM that visits one node per clock.
- Traversal output is streamed with backpressure. Sits between the button/switch front-end and the LED/display logic.

---
 rtl/bst_pkg.sv | 30 +++
 rtl/bst_node_ram.sv | 49 ++++
 rtl/bst_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bst_pkg
// Purpose  : Shared op encodings, FSM state type and NIL helper for the
//            binary-search-tree key store.
// Revision : 1.0 - initial release
// ============================================================================
package bst_pkg;

    localparam logic [1:0] OP_FIND   = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_TRAV   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WALK      = 3'd1,
        ST_LINK      = 3'd2,
        ST_TRAV_DESC = 3'd3,
        ST_TRAV_EMIT = 3'd4,
        ST_DONE      = 3'd5
    } bst_state_t;

    // The first out-of-range index doubles as the null link.
    function automatic int unsigned nil_from_depth(input int unsigned depth);
        return depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bst_node_ram.sv
`default_nettype none
// ============================================================================
// Module   : bst_node_ram
// Purpose  : Node storage (key, left link, right link); one async read port,
//            one synchronous write port that updates a whole node.
// Revision : 1.0 - initial release
// ============================================================================
module bst_node_ram
    import bst_pkg::*;
#(
    parameter int KEY_W = 4,
    parameter int DEPTH = 7,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic [IDX_W-1:0] rd_left,
    output logic [IDX_W-1:0] rd_right,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [IDX_W-1:0] wr_left,
    input  logic [IDX_W-1:0] wr_right
);

    localparam logic [IDX_W-1:0] c_nil = IDX_W'(nil_from_depth(DEPTH));

    logic [KEY_W-1:0] r_key_mem [DEPTH];
    logic [IDX_W-1:0] r_left    [DEPTH];
    logic [IDX_W-1:0] r_right   [DEPTH];
    logic             w_rd_ok;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_key_mem[wr_idx] <= wr_key;
            r_left[wr_idx]    <= wr_left;
            r_right[wr_idx]   <= wr_right;
        end
    end

    // A NIL address reads back as an empty leaf rather than out-of-range data.
    assign w_rd_ok  = (rd_idx < c_nil);
    assign rd_key   = w_rd_ok ? r_key_mem[rd_idx] : '0;
    assign rd_left  = w_rd_ok ? r_left[rd_idx]    : c_nil;
    assign rd_right = w_rd_ok ? r_right[rd_idx]   : c_nil;

endmodule
`default_nettype wire

// File: rtl/bst_engine.sv
`default_nettype none
// ============================================================================
// Module   : bst_engine
// Purpose  : Binary-search-tree key store with find/insert/clear and a
//            backpressured in-order traversal stream; one node per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bst_engine
    import bst_pkg::*;
#(
    parameter int KEY_W = 4,
    parameter int DEPTH = 7,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             rsp_valid,
    output logic             rsp_found,
    output logic             rsp_err,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             trav_valid,
    input  logic             trav_ready,
    output logic [KEY_W-1:0] trav_key,
    output logic             trav_last,
    output logic [IDX_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic [IDX_W-1:0] c_nil   = IDX_W'(nil_from_depth(DEPTH));
    localparam logic [IDX_W-1:0] c_depth = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] c_one   = IDX_W'(1);

    bst_state_t       r_state, w_state_nxt;
    logic [1:0]       r_op;
    logic [KEY_W-1:0] r_key;
    logic [IDX_W-1:0] r_cur, r_root, r_count, r_sp, r_idx;
    logic             r_found, r_err, r_new_root;
    logic [IDX_W-1:0] r_stack [DEPTH];

    logic [IDX_W-1:0] w_rd_idx, w_rd_left, w_rd_right, w_top, w_child;
    logic [KEY_W-1:0] w_rd_key;
    logic             w_eq, w_lt, w_miss;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx, w_wr_left, w_wr_right;
    logic [KEY_W-1:0] w_wr_key;

    bst_node_ram #(.KEY_W(KEY_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .clk      (clk),
        .rd_idx   (w_rd_idx),
        .rd_key   (w_rd_key),
        .rd_left  (w_rd_left),
        .rd_right (w_rd_right),
        .wr_en    (w_wr_en),
        .wr_idx   (w_wr_idx),
        .wr_key   (w_wr_key),
        .wr_left  (w_wr_left),
        .wr_right (w_wr_right)
    );

    assign w_top    = r_stack[r_sp - c_one];
    assign w_rd_idx = (r_state == ST_TRAV_EMIT) ? w_top : r_cur;
    assign w_eq     = (r_key == w_rd_key);
    assign w_lt     = (r_key < w_rd_key);
    assign w_child  = w_lt ? w_rd_left : w_rd_right;
    assign w_miss   = !w_eq && (w_child == c_nil);

    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_FIND:   w_state_nxt = (r_root == c_nil) ? ST_DONE : ST_WALK;
                        OP_INSERT: w_state_nxt = (full || r_root == c_nil) ? ST_DONE : ST_WALK;
                        OP_CLEAR:  w_state_nxt = ST_DONE;
                        default:   w_state_nxt = (r_root == c_nil) ? ST_DONE : ST_TRAV_DESC;
                    endcase
                end
            end
            ST_WALK: begin
                if (w_eq)        w_state_nxt = ST_DONE;
                else if (w_miss) w_state_nxt = (r_op == OP_INSERT) ? ST_LINK : ST_DONE;
            end
            ST_LINK:      w_state_nxt = ST_DONE;
            ST_TRAV_DESC: if (w_rd_left == c_nil) w_state_nxt = ST_TRAV_EMIT;
            ST_TRAV_EMIT: begin
                if (trav_ready) begin
                    if (w_rd_right != c_nil) w_state_nxt = ST_TRAV_DESC;
                    else if (r_sp == c_one)  w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Parent link goes in on the final WALK cycle, so LINK only has to
    // write the fresh node and the single write port suffices.
    always_comb begin
        cmd_ready  = (r_state == ST_IDLE);
        trav_valid = (r_state == ST_TRAV_EMIT);
        trav_key   = '0;
        trav_last  = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_idx   = r_count;
        w_wr_key   = r_key;
        w_wr_left  = c_nil;
        w_wr_right = c_nil;
        case (r_state)
            ST_WALK: begin
                if (w_miss && r_op == OP_INSERT) begin
                    w_wr_en    = 1'b1;
                    w_wr_idx   = r_cur;
                    w_wr_key   = w_rd_key;
                    w_wr_left  = w_lt ? r_count : w_rd_left;
                    w_wr_right = w_lt ? w_rd_right : r_count;
                end
            end
            ST_LINK:      w_wr_en = 1'b1;
            ST_TRAV_EMIT: begin
                trav_key  = w_rd_key;
                trav_last = (r_sp == c_one) && (w_rd_right == c_nil);
            end
            ST_DONE:      w_wr_en = r_new_root;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_FIND;
            r_key      <= '0;
            r_cur      <= c_nil;
            r_root     <= c_nil;
            r_count    <= '0;
            r_sp       <= '0;
            r_idx      <= c_nil;
            r_found    <= 1'b0;
            r_err      <= 1'b0;
            r_new_root <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_found  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_idx    <= c_nil;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_key      <= cmd_key;
                        r_cur      <= r_root;
                        r_sp       <= '0;
                        r_idx      <= c_nil;
                        r_found    <= 1'b0;
                        r_err      <= (cmd_op == OP_INSERT) && full;
                        r_new_root <= (cmd_op == OP_INSERT) && (r_root == c_nil);
                    end
                end
                ST_WALK: begin
                    if (w_eq) begin
                        r_found <= 1'b1;
                        r_idx   <= r_cur;
                    end else if (!w_miss) begin
                        r_cur <= w_child;
                    end
                end
                ST_LINK: begin
                    r_idx   <= r_count;
                    r_count <= r_count + c_one;
                end
                ST_TRAV_DESC: begin
                    r_sp <= r_sp + c_one;
                    if (w_rd_left != c_nil) r_cur <= w_rd_left;
                end
                ST_TRAV_EMIT: begin
                    if (trav_ready) begin
                        r_sp <= r_sp - c_one;
                        if (w_rd_right != c_nil) r_cur <= w_rd_right;
                    end
                end
                ST_DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_found <= r_found;
                    rsp_err   <= r_err;
                    rsp_idx   <= r_idx;
                    if (r_op == OP_CLEAR) begin
                        r_count <= '0;
                        r_root  <= c_nil;
                    end
                    if (r_new_root) begin
                        r_root  <= '0;
                        r_count <= c_one;
                        rsp_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_TRAV_DESC) r_stack[r_sp] <= r_cur;
    end

endmodule
`default_nettype wire
